// File: rtl/nios_led_sequencer.sv
// Avalon-MM LED pattern sequencer: CPU loads a pattern table, then the block strobes the LED PIO.
// Optional build macro LED_SEQ_IRQ_EN adds the irq output and the STATUS.IRQ_EN bit.
module nios_led_sequencer #(
    parameter int unsigned LED_WIDTH    = 4,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned PERIOD_WIDTH = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  DepthL = 4'(DEPTH);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StStrobe = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [3:0]              index_q, index_d;
    logic [PERIOD_WIDTH-1:0] count_q, count_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_eff;
    logic [3:0]              length_q, len_eff;
    logic [LED_WIDTH-1:0]    pattern_q [DEPTH];
    logic                    run_q, loop_q, done_q, done_d;
    logic                    irq_en;
    logic                    wr_en, ctrl_wr, status_wr, pat_sel, busy;
    logic                    advance, abort, done_set, run_clr;
    logic [3:0]              pat_off;

    assign wr_en     = chipselect & ~write_n;
    assign ctrl_wr   = wr_en && (address == 4'd0);
    assign status_wr = wr_en && (address == 4'd1);
    assign pat_off   = address - 4'd4;
    assign pat_sel   = (address >= 4'd4) && ({28'd0, pat_off} < DEPTH);
    assign busy      = (state_q != StIdle);
    assign abort     = ctrl_wr && !writedata[0] && busy;

    assign period_eff = (period_q == '0) ? PERIOD_WIDTH'(1) : period_q;
    assign len_eff    = (length_q == 4'd0) ? 4'd1 : ((length_q > DepthL) ? DepthL : length_q);

    always_comb begin
        readdata = '0;
        case (address)
            4'd0: readdata[1:0] = {loop_q, run_q};
            4'd1: readdata[2:0] = {irq_en, done_q, busy};
            4'd2: readdata[PERIOD_WIDTH-1:0] = period_q;
            4'd3: readdata[3:0] = length_q;
            default: if (pat_sel) readdata[LED_WIDTH-1:0] = pattern_q[pat_off[IdxW-1:0]];
        endcase
    end

    // The counter covers PERIOD-1 WAIT cycles, so strobes land exactly PERIOD cycles apart.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        count_d  = count_q;
        advance  = 1'b0;
        done_set = 1'b0;
        run_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run_q) begin
                    index_d = 4'd0;
                    state_d = StStrobe;
                end
            end
            StStrobe: begin
                count_d = period_eff - PERIOD_WIDTH'(1);
                if (period_eff == PERIOD_WIDTH'(1)) advance = 1'b1;
                else state_d = StWait;
            end
            StWait: begin
                count_d = count_q - PERIOD_WIDTH'(1);
                if (count_q == PERIOD_WIDTH'(1)) advance = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        if (advance) begin
            if (4'(index_q + 4'd1) < len_eff) begin
                index_d = 4'(index_q + 4'd1);
                state_d = StStrobe;
            end else if (loop_q) begin
                index_d = 4'd0;
                state_d = StStrobe;
            end else begin
                done_set = 1'b1;
                run_clr  = 1'b1;
                state_d  = StIdle;
            end
        end
        if (abort) begin
            state_d  = StIdle;
            done_set = 1'b0;
            run_clr  = 1'b0;
        end
    end

    // A completion landing on the same edge as a write-1-to-clear keeps DONE set.
    assign done_d = done_set | (done_q & ~(status_wr & writedata[1]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            index_q  <= 4'd0;
            count_q  <= '0;
            period_q <= '0;
            length_q <= 4'd0;
            run_q    <= 1'b0;
            loop_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) pattern_q[i] <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            count_q <= count_d;
            done_q  <= done_d;
            if (ctrl_wr) begin
                run_q  <= writedata[0];
                loop_q <= writedata[1];
            end
            if (run_clr) run_q <= 1'b0;
            if (wr_en && address == 4'd2) period_q <= writedata[PERIOD_WIDTH-1:0];
            if (wr_en && address == 4'd3) length_q <= writedata[3:0];
            if (wr_en && pat_sel) pattern_q[pat_off[IdxW-1:0]] <= writedata[LED_WIDTH-1:0];
        end
    end

`ifdef LED_SEQ_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;

    assign irq_en_d = status_wr ? writedata[2] : irq_en_q;
    assign irq_en   = irq_en_q;
    assign irq      = irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= done_d & irq_en_d;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    assign m_address    = 2'd0;
    assign m_chipselect = (state_q == StStrobe);
    assign m_write_n    = ~m_chipselect;
    assign m_writedata  = {{(32 - LED_WIDTH){1'b0}}, pattern_q[index_q[IdxW-1:0]]};

endmodule

// File: tb/tb_nios_led_sequencer.sv
// Directed bench for nios_led_sequencer; irq checks are built only with LED_SEQ_IRQ_EN.
module tb_nios_led_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
`ifdef LED_SEQ_IRQ_EN
    logic        irq;
`endif

    nios_led_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata)
`ifdef LED_SEQ_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          vectors = 0;
    int          errs = 0;
    int          wr_cyc;
    int          done_cyc = -1;
    int          n;
    int          s_cyc [$];
    logic [31:0] s_dat [$];
    logic [31:0] rd;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every master write strobe and the first cycle DONE is visible on STATUS.
    always @(negedge clk) begin
        if (m_chipselect && !m_write_n) begin
            s_cyc.push_back(cyc);
            s_dat.push_back(m_writedata);
        end
        if (address == 4'd1 && readdata[1] && done_cyc < 0) done_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        wr_cyc     = cyc;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic clear_log();
        s_cyc.delete();
        s_dat.delete();
        done_cyc = -1;
    endtask

    initial begin
        reset_n = 1'b0; address = 4'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        tick(3);
        for (int a = 0; a < 5; a++) begin
            cpu_read(4'(a), rd); chk($sformatf("reset_reg%0d", a), rd, 32'd0);
        end
        chk("reset_m_cs", {31'd0, m_chipselect}, 32'd0);
        chk("reset_m_wn", {31'd0, m_write_n}, 32'd1);
        chk("reset_m_data", m_writedata, 32'd0);
        chk("reset_m_addr", {30'd0, m_address}, 32'd0);
        reset_n = 1'b1;
        tick(1);

        // Unmapped address beyond the table ignores writes and reads 0.
        cpu_write(4'd12, 32'h5);
        cpu_read(4'd12, rd); chk("unmapped_read", rd, 32'd0);

        // One-shot 1,2,4,8 at PERIOD=10.
        for (int i = 0; i < 4; i++) cpu_write(4'(4 + i), 32'd1 << i);
        cpu_write(4'd3, 32'd4);
        cpu_write(4'd2, 32'd10);
        cpu_read(4'd2, rd); chk("period_rb", rd, 32'd10);
        clear_log();
        cpu_write(4'd0, 32'd1);
        n = wr_cyc;
        address = 4'd1;
        tick(50);
        chk("once_count", s_cyc.size(), 32'd4);
        for (int k = 0; k < 4 && k < s_cyc.size(); k++) begin
            chk($sformatf("once_cyc%0d", k), s_cyc[k], n + 1 + 10 * k);
            chk($sformatf("once_dat%0d", k), s_dat[k], 32'd1 << k);
        end
        chk("once_done_cyc", done_cyc, n + 41);
        cpu_read(4'd0, rd); chk("once_ctrl", rd, 32'd0);
        cpu_read(4'd1, rd); chk("once_status", rd, 32'd2);
        cpu_write(4'd1, 32'd2);
        cpu_read(4'd1, rd); chk("done_w1c", rd, 32'd0);

        // Looping run for 100 cycles.
        clear_log();
        cpu_write(4'd0, 32'd3);
        n = wr_cyc;
        address = 4'd1;
        tick(100);
        chk("loop_count", s_cyc.size(), 32'd10);
        for (int k = 0; k < 10 && k < s_cyc.size(); k++) begin
            chk($sformatf("loop_cyc%0d", k), s_cyc[k], n + 1 + 10 * k);
            chk($sformatf("loop_dat%0d", k), s_dat[k], 32'd1 << (k % 4));
        end
        chk("loop_no_done", done_cyc, -1);
        cpu_read(4'd1, rd); chk("loop_busy", rd, 32'd1);
        cpu_write(4'd0, 32'd0);
        tick(2);

        // Abort in the cycle after the second strobe.
        clear_log();
        cpu_write(4'd0, 32'd3);
        n = wr_cyc;
        tick(12);
        cpu_write(4'd0, 32'd0);
        tick(30);
        chk("abort_count", s_cyc.size(), 32'd2);
        cpu_read(4'd1, rd); chk("abort_status", rd, 32'd0);
        cpu_read(4'd0, rd); chk("abort_ctrl", rd, 32'd0);

        // PERIOD=0 and LENGTH=0 both act as 1.
        cpu_write(4'd2, 32'd0);
        cpu_write(4'd3, 32'd0);
        cpu_write(4'd4, 32'hF);
        clear_log();
        cpu_write(4'd0, 32'd1);
        n = wr_cyc;
        address = 4'd1;
        tick(5);
        chk("min_count", s_cyc.size(), 32'd1);
        if (s_cyc.size() > 0) begin
            chk("min_cyc", s_cyc[0], n + 1);
            chk("min_dat", s_dat[0], 32'hF);
        end
        chk("min_done_cyc", done_cyc, n + 2);
        cpu_write(4'd1, 32'd2);

        // DONE set and write-1-to-clear on the same edge: set wins.
        cpu_write(4'd0, 32'd1);
        tick(1);
        cpu_write(4'd1, 32'd2);
        cpu_read(4'd1, rd); chk("set_wins", rd, 32'd2);
        cpu_write(4'd1, 32'd2);
        cpu_read(4'd1, rd); chk("set_wins_clr", rd, 32'd0);

        // LENGTH above DEPTH clamps to DEPTH; PERIOD=1 strobes back to back.
        for (int i = 0; i < 8; i++) cpu_write(4'(4 + i), 32'(i + 1));
        cpu_write(4'd3, 32'd15);
        cpu_write(4'd2, 32'd1);
        clear_log();
        cpu_write(4'd0, 32'd1);
        n = wr_cyc;
        tick(15);
        chk("clamp_count", s_cyc.size(), 32'd8);
        for (int k = 0; k < 8 && k < s_cyc.size(); k++) begin
            chk($sformatf("clamp_cyc%0d", k), s_cyc[k], n + 1 + k);
            chk($sformatf("clamp_dat%0d", k), s_dat[k], 32'(k + 1));
        end
        cpu_write(4'd1, 32'd2);

`ifdef LED_SEQ_IRQ_EN
        cpu_write(4'd1, 32'd4);
        cpu_read(4'd1, rd); chk("irq_en_rb", rd, 32'd4);
        cpu_write(4'd3, 32'd1);
        cpu_write(4'd2, 32'd0);
        cpu_write(4'd0, 32'd1);
        tick(4);
        chk("irq_set", {31'd0, irq}, 32'd1);
        cpu_write(4'd1, 32'd2);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        cpu_read(4'd1, rd); chk("irq_status", rd, 32'd0);
`endif

        // Reset in the middle of a looping run.
        cpu_write(4'd2, 32'd100);
        cpu_write(4'd0, 32'd3);
        tick(50);
        reset_n = 1'b0;
        #1;
        chk("rst_m_cs", {31'd0, m_chipselect}, 32'd0);
        chk("rst_m_wn", {31'd0, m_write_n}, 32'd1);
        chk("rst_m_data", m_writedata, 32'd0);
        for (int a = 0; a < 5; a++) begin
            cpu_read(4'(a), rd); chk($sformatf("rst_reg%0d", a), rd, 32'd0);
        end
        tick(2);
        reset_n = 1'b1;
        clear_log();
        tick(120);
        chk("rst_no_strobe", s_cyc.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/nios_led_sequencer.md
Name: nios_led_sequencer

Overview:
Avalon-MM controller that drives the 4-bit LED PIO slave with no CPU involvement per step. The Nios CPU loads a small pattern table, a step period and a length through this block's slave port, then sets RUN. The block then issues single-cycle Avalon writes to PIO address 0 on its master port, stepping through the table once or looping. It sits between the CPU data master and the LED PIO's s1 slave.

Parameters:
LED_WIDTH, 4, width of pattern entries and of m_writedata[LED_WIDTH-1:0]
DEPTH, 8, pattern table entries (1..12)
PERIOD_WIDTH, 24, width of PERIOD register / step counter

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  4  slave register word address
chipselect  input  1  slave select
write_n  input  1  slave write strobe, active low
writedata  input  32  slave write data
readdata  output  32  slave read data, combinational from address, zero read latency
m_address  output  2  master address to LED PIO, constant 0
m_chipselect  output  1  master select to LED PIO
m_write_n  output  1  master write strobe, active low
m_writedata  output  32  {zero-extend, pattern entry}
irq  output  1  done interrupt, present only with LED_SEQ_IRQ_EN

Behaviour:
- One clock (clk); reset_n asynchronous, active-low. All state clears immediately on reset assertion.
- Reset values: readdata follows registers (all 0), m_address=0, m_chipselect=0, m_write_n=1, m_writedata=0, irq=0.
- Slave write accepted when chipselect && !write_n. Reads have no side effects.
- Register map:
  - 0 CTRL: bit0 RUN, bit1 LOOP; R/W.
  - 1 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write 1 to clear), bit2 IRQ_EN (R/W).
  - 2 PERIOD: PERIOD_WIDTH bits; value 0 is treated as 1.
  - 3 LENGTH: 4 bits; 0 is treated as 1; values above DEPTH are treated as DEPTH.
  - 4..4+DEPTH-1 PATTERN[i]: LED_WIDTH bits.
  - Unmapped addresses read 0 and ignore writes.
- FSM states: IDLE, STROBE, WAIT.
  - IDLE: when RUN is 1 and not BUSY: index=0, go to STROBE.
  - STROBE: exactly one cycle with m_chipselect=1, m_write_n=0, m_writedata=PATTERN[index]; load counter=PERIOD-1; go to WAIT.
  - WAIT: decrement the counter. At 0, index+1: if index+1 < LENGTH, go to STROBE. Else if LOOP, index=0 and go to STROBE. Else set DONE, clear RUN, go to IDLE.
- Timing: the first strobe occurs in the 2nd cycle after the edge that accepts the RUN write. Consecutive strobes are exactly max(PERIOD,1) cycles apart. DONE sets max(PERIOD,1) cycles after the last strobe.
- BUSY=1 in STROBE/WAIT.
- Writing RUN=0 while BUSY aborts: FSM returns to IDLE on the next edge and issues no further strobes; the LED keeps its last value; DONE is not set. If the abort write lands in the same cycle as a STROBE, that strobe still completes.
- PATTERN, LENGTH and LOOP writes during a run take effect when next sampled. PERIOD is sampled only at STROBE.
- Simultaneous DONE set and CPU write-1-to-clear in the same cycle: the set wins.
- Writing RUN=1 while already BUSY has no effect (no restart).
- The master has no waitrequest; the PIO accepts every write in one cycle.

Optional Feature:
LED_SEQ_IRQ_EN
- Defined: the irq port exists; irq = DONE & IRQ_EN, registered, cleared by writing 1 to STATUS.DONE.
- Undefined: no irq port; STATUS.IRQ_EN reads 0 and ignores writes; DONE still functions for polling.

Test Plan:
- Reset mid-run (PERIOD=100, LOOP=1, assert reset_n=0 at cycle 50) -> all master outputs idle immediately, registers read 0, no strobe after release.
- PATTERN={1,2,4,8}, LENGTH=4, PERIOD=10, LOOP=0, write CTRL=1 -> 4 strobes with data 1,2,4,8 spaced 10 cycles apart, first at +2 cycles; DONE=1 10 cycles after the 4th strobe; CTRL reads 0.
- Same config with LOOP=1, run 100 cycles -> strobe data repeats 1,2,4,8,1,2,...; DONE stays 0; BUSY=1 throughout.
- PERIOD=0, LENGTH=0, PATTERN[0]=0xF -> one strobe with data 0xF, DONE 1 cycle later.
- Looping run, write CTRL=0 in the cycle after the 2nd strobe -> no 3rd strobe; BUSY=0; DONE=0.
- With LED_SEQ_IRQ_EN and IRQ_EN=1, completed run -> irq=1. Write STATUS=0x2 -> irq=0 next cycle. Set and clear in the same cycle -> DONE stays 1.
